// File: rtl/csi2_px_deserializer_wide_if.sv
// csi2_px_deserializer_wide_if: AXI4-Stream bundle shared by the pixel deserializer's input and output sides
interface axi4_stream_if #(
    parameter int DW = 8
);
    localparam int KW = (DW + 7) / 8;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic [KW-1:0] tstrb;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;
    logic          tid;
    logic          tdest;
    modport master(output tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest, input tready);
    modport slave(input tdata, tkeep, tstrb, tvalid, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/csi2_px_deserializer_wide.sv
// csi2_px_deserializer_wide: splits each packed multi-pixel stream word into RATIO zero-extended beats, LSB pixel first
module csi2_px_deserializer_wide #(
    parameter int PX_W     = 10,
    parameter int IN_PX    = 4,
    parameter int OUT_PX   = 1,
    parameter int OUT_PX_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 frame_start_i,
    axi4_stream_if.slave         pkt_i,
    axi4_stream_if.master        pkt_o,
    output logic [15:0]          line_px_o
);
    localparam int RATIO = IN_PX / OUT_PX;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int IN_W  = IN_PX * PX_W;

    if (IN_PX % OUT_PX != 0) begin : g_bad_ratio
        $error("IN_PX must be a multiple of OUT_PX");
    end
    if (OUT_PX_W < PX_W) begin : g_bad_width
        $error("OUT_PX_W must be at least PX_W");
    end

    logic [IN_W-1:0] data_q;
    logic            last_q;
    logic            user_q;
    logic            full_q;
    logic            start_q;
    logic [IW-1:0]   idx;
    logic            last_slice;
    logic            in_hs;
    logic            out_hs;
    logic [16:0]     line_sum;

    assign last_slice   = idx == IW'(RATIO - 1);
    assign pkt_i.tready = !full_q || (pkt_o.tready && last_slice);
    assign in_hs        = pkt_i.tvalid && pkt_i.tready;
    assign out_hs       = full_q && pkt_o.tready;
    assign line_sum     = {1'b0, line_px_o} + 17'(OUT_PX);

    // a new word may only land while the final slice of the held word leaves
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            last_q    <= 1'b0;
            user_q    <= 1'b0;
            full_q    <= 1'b0;
            start_q   <= 1'b0;
            idx       <= '0;
            line_px_o <= '0;
        end else begin
            if (in_hs) begin
                data_q <= pkt_i.tdata;
                last_q <= pkt_i.tlast;
                user_q <= start_q;
                full_q <= 1'b1;
                idx    <= '0;
            end else if (out_hs) begin
                idx    <= last_slice ? '0 : idx + 1'b1;
                full_q <= !last_slice;
            end
            start_q <= frame_start_i || (start_q && !in_hs);
            if (out_hs)
                line_px_o <= pkt_o.tlast ? '0 : line_sum[16] ? 16'hFFFF : line_sum[15:0];
        end
    end

    for (genvar k = 0; k < OUT_PX; k++) begin : g_px
        assign pkt_o.tdata[k*OUT_PX_W +: OUT_PX_W] = OUT_PX_W'(data_q[(int'(idx) * OUT_PX + k) * PX_W +: PX_W]);
    end

    assign pkt_o.tvalid = full_q;
    assign pkt_o.tuser  = user_q && idx == '0;
    assign pkt_o.tlast  = last_q && last_slice;
    assign pkt_o.tkeep  = '1;
    assign pkt_o.tstrb  = '1;
    assign pkt_o.tid    = 1'b0;
    assign pkt_o.tdest  = 1'b0;
endmodule

// File: tb/tb_csi2_px_deserializer_wide.sv
// tb_csi2_px_deserializer_wide: directed and random stimulus against a pixel-queue model of the deserializer
module tb_csi2_px_deserializer_wide;
    localparam int PX_W = 10, IN_PX = 4, OUT_PX = 1, OUT_PX_W = 16;

    typedef struct {
        logic [15:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_start2 = 1'b0;
    logic [15:0] line_px;
    logic [15:0] line2;
    logic        ready_set = 1'b1;
    logic        rand_rdy = 1'b0;
    logic        rnd_bit = 1'b1;

    axi4_stream_if #(.DW(40)) in_if ();
    axi4_stream_if #(.DW(16)) out_if ();
    axi4_stream_if #(.DW(48)) in2 ();
    axi4_stream_if #(.DW(32)) out2 ();

    csi2_px_deserializer_wide dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start),
        .pkt_i(in_if.slave), .pkt_o(out_if.master), .line_px_o(line_px)
    );

    csi2_px_deserializer_wide #(.PX_W(12), .IN_PX(4), .OUT_PX(2), .OUT_PX_W(16)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start2),
        .pkt_i(in2.slave), .pkt_o(out2.master), .line_px_o(line2)
    );

    always #5 clk_i = ~clk_i;

    always begin
        @(posedge clk_i);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    assign out_if.tready = rand_rdy ? rnd_bit : ready_set;
    assign out2.tready   = 1'b1;

    int          tests = 0, fails = 0, cyc = 0;
    beat_t       q[$];
    logic        m_flag = 1'b0;
    logic [15:0] m_line = '0;
    logic        in_hs_n = 1'b0;
    logic        stalled = 1'b0;
    logic [15:0] st_d;
    logic        st_u, st_l;
    logic [15:0] cap_d[16];
    logic        cap_u[16], cap_l[16];
    logic [15:0] cap_line[16];
    int          cap_c[16];
    int          cap_n = 0, tuser_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: each accepted word becomes IN_PX pixel beats; one word in flight at most
    always @(negedge clk_i) begin
        beat_t b;
        cyc++;
        if (rst_i) begin
            q.delete();
            m_flag = 1'b0;
            m_line = '0;
            stalled = 1'b0;
            in_hs_n = 1'b0;
            chk("rst_tvalid", out_if.tvalid, 0);
            chk("rst_in_tready", in_if.tready, 1);
            chk("rst_tdata", out_if.tdata, 0);
            chk("rst_tuser", out_if.tuser, 0);
            chk("rst_tlast", out_if.tlast, 0);
            chk("rst_line", line_px, 0);
        end else begin
            chk("tvalid", out_if.tvalid, q.size() != 0);
            chk("in_tready", in_if.tready, q.size() == 0 || (q.size() == 1 && out_if.tready));
            chk("line_px", line_px, m_line);
            if (stalled) begin
                chk("stall_tvalid", out_if.tvalid, 1);
                chk("stall_tdata", out_if.tdata, st_d);
                chk("stall_tuser", out_if.tuser, st_u);
                chk("stall_tlast", out_if.tlast, st_l);
            end
            if (out_if.tvalid && q.size() != 0) begin
                b = q[0];
                chk("tdata", out_if.tdata, b.d);
                chk("tuser", out_if.tuser, b.u);
                chk("tlast", out_if.tlast, b.l);
            end
            stalled = out_if.tvalid && !out_if.tready;
            st_d = out_if.tdata;
            st_u = out_if.tuser;
            st_l = out_if.tlast;
            if (out_if.tvalid && out_if.tready) begin
                if (cap_n < 16) begin
                    cap_d[cap_n] = out_if.tdata;
                    cap_u[cap_n] = out_if.tuser;
                    cap_l[cap_n] = out_if.tlast;
                    cap_line[cap_n] = line_px;
                    cap_c[cap_n] = cyc;
                end
                cap_n++;
                if (out_if.tuser) tuser_cnt++;
                if (q.size() != 0) begin
                    b = q.pop_front();
                    m_line = b.l ? 16'd0 : (m_line == 16'hFFFF ? m_line : m_line + 16'(OUT_PX));
                end
            end
            in_hs_n = in_if.tvalid && in_if.tready;
            if (in_hs_n)
                for (int i = 0; i < IN_PX; i++) begin
                    b.d = 16'((in_if.tdata >> (i * PX_W)) & 40'h3FF);
                    b.u = m_flag && i == 0;
                    b.l = in_if.tlast && i == IN_PX - 1;
                    q.push_back(b);
                end
            m_flag = frame_start || (m_flag && !in_hs_n);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [39:0] w, input logic l);
        int n = 0;
        in_if.tvalid = 1'b1;
        in_if.tdata = w;
        in_if.tlast = l;
        do begin
            @(posedge clk_i);
            n++;
        end while (!in_hs_n && n < 1000);
        #1;
        chk("send_accept", in_hs_n, 1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_if.tvalid) && n < 4000) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    logic [15:0] e1[8] = '{16'h001, 16'h010, 16'h3F0, 16'h3FF, 16'h002, 16'h002, 16'h010, 16'h000};

    initial begin
        int base, n;
        logic [63:0] r;
        in_if.tvalid = 0; in_if.tdata = '0; in_if.tlast = 0; in_if.tuser = 0;
        in_if.tkeep = '1; in_if.tstrb = '1; in_if.tid = 0; in_if.tdest = 0;
        in2.tvalid = 0; in2.tdata = '0; in2.tlast = 0; in2.tuser = 0;
        in2.tkeep = '1; in2.tstrb = '1; in2.tid = 0; in2.tdest = 0;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        // two back-to-back words; pixels of the first are 0x001,0x010,0x3F0,0x3FF
        cap_n = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        send(40'hFF_FF00_4001, 1'b0);
        send(40'h00_0100_0802, 1'b1);
        drain();
        for (int i = 0; i < 8; i++) begin
            chk("t1_beat", cap_d[i], e1[i]);
            chk("t1_tuser", cap_u[i], i == 0);
            chk("t1_tlast", cap_l[i], i == 7);
        end
        chk("t1_no_bubble", cap_c[7] - cap_c[0], 7);
        chk("t1_line_at_beat7", cap_line[7], 7);
        chk("t1_line_end", line_px, 0);

        // start pulse coincident with accept, then repeated pulses
        base = tuser_cnt;
        frame_start = 1'b1;
        send(40'h11_2233_4455, 1'b0);
        frame_start = 1'b0;
        drain();
        chk("t4_coincident_untagged", tuser_cnt - base, 0);
        send(40'h66_7788_99AA, 1'b1);
        drain();
        chk("t4_next_tagged", tuser_cnt - base, 1);
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        send(40'h01_0203_0405, 1'b0);
        send(40'h06_0708_090A, 1'b1);
        drain();
        chk("t4_single_tuser", tuser_cnt - base, 2);

        // two-pixel output beats, 12-bit pixels
        in2.tvalid = 1'b1;
        in2.tdata = 48'hABC_123_456_789;
        in2.tlast = 1'b1;
        tick();
        in2.tvalid = 1'b0;
        chk("t3_valid0", out2.tvalid, 1);
        chk("t3_beat0", out2.tdata, 32'h0456_0789);
        chk("t3_tuser0", out2.tuser, 0);
        tick();
        chk("t3_beat1", out2.tdata, 32'h0ABC_0123);
        chk("t3_tlast1", out2.tlast, 1);
        chk("t3_line1", line2, 2);
        tick();
        chk("t3_idle", out2.tvalid, 0);
        chk("t3_line_end", line2, 0);

        // reset mid-word while stalled
        cap_n = 0;
        send(40'hAA_BBCC_DDEE, 1'b0);
        n = 0;
        while (cap_n < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach_idx2", cap_n, 2);
        ready_set = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("t5_tvalid_async", out_if.tvalid, 0);
        chk("t5_in_tready", in_if.tready, 1);
        chk("t5_line", line_px, 0);
        tick();
        tick();
        rst_i = 1'b0;
        ready_set = 1'b1;
        tick();
        cap_n = 0;
        send(40'h00_0C03_00C1, 1'b1);
        drain();
        chk("t5_beats", cap_n, 4);
        chk("t5_first_px", cap_d[0], 16'h00C1);

        // random words under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            r = {$urandom(), $urandom()};
            if ($urandom_range(0, 15) == 0) frame_start = 1'b1;
            send(r[39:0], i == 999 || $urandom_range(0, 7) == 0);
            frame_start = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_rdy = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end
endmodule
